// File: rtl/ram_wait_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module  : ram_wait_ctrl_pkg
// Purpose : Shared encodings for the wait-state memory controller: access
//           size codes, FSM states, read/write polarity and the access-fault
//           check used at request accept.
// Ports   : none (package)
// Revision: 1.0 - initial release
// ============================================================================
package ram_wait_ctrl_pkg;

  // Access size carried on the TYPE field of a request.
  typedef enum logic [1:0] {
    TYPE_BYTE = 2'b00,
    TYPE_HALF = 2'b01,
    TYPE_WORD = 2'b10,
    TYPE_RSVD = 2'b11
  } acc_type_e;

  // Controller FSM states.
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_ACK  = 2'd2
  } state_e;

  localparam logic RW_READ  = 1'b1;
  localparam logic RW_WRITE = 1'b0;

  // A request faults on the reserved size, a misaligned halfword/word, or an
  // address outside the storage range (i_oob).
  function automatic logic access_fault(input logic [1:0] i_typ,
                                        input logic [1:0] i_lsb,
                                        input logic       i_oob);
    logic w_bad;
    w_bad = 1'b0;
    case (acc_type_e'(i_typ))
      TYPE_BYTE: w_bad = 1'b0;
      TYPE_HALF: w_bad = i_lsb[0];
      TYPE_WORD: w_bad = |i_lsb;
      default:   w_bad = 1'b1;
    endcase
    return w_bad | i_oob;
  endfunction

endpackage
`default_nettype wire

// File: rtl/ram_wait_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module  : ram_wait_ctrl_if
// Purpose : MOV/MOC handshake bus between a requester (control unit side)
//           and the wait-state memory.
// Signals : mov      - operation valid, held until moc seen
//           rw       - 1 read / 0 write
//           typ      - access size (byte/half/word/reserved)
//           addr     - byte address
//           data_in  - right-justified write data
//           data_out - right-justified read data
//           moc      - operation complete
//           err      - access faulted, qualifies moc
//           busy     - request accepted and not yet released
// Revision: 1.0 - initial release
// ============================================================================
interface ram_wait_ctrl_if #(
  parameter int ADDR_W = 32
) ();
  logic              mov;
  logic              rw;
  logic [1:0]        typ;
  logic [ADDR_W-1:0] addr;
  logic [31:0]       data_in;
  logic [31:0]       data_out;
  logic              moc;
  logic              err;
  logic              busy;

  modport master (
    output mov, rw, typ, addr, data_in,
    input  data_out, moc, err, busy
  );

  modport slave (
    input  mov, rw, typ, addr, data_in,
    output data_out, moc, err, busy
  );
endinterface
`default_nettype wire

// File: rtl/ram_wait_ctrl_byte_array.sv
`default_nettype none
// ============================================================================
// Module  : ram_byte_array
// Purpose : Byte-wide storage with four lanes at a, a+1, a+2, a+3 (modulo
//           DEPTH). Lane k occupies bits [31-8k -: 8] of the data buses, so
//           lane 0 is the most significant byte (big-endian).
// Ports   : clk     - clock, rising edge
//           i_addr  - base byte address
//           i_we    - per-lane write enables (bit k = lane k)
//           i_wdata - lane-packed write data
//           o_rdata - lane-packed asynchronous read data
// Revision: 1.0 - initial release
// ============================================================================
module ram_byte_array #(
  parameter int DEPTH = 256,
  parameter int AW    = $clog2(DEPTH)
) (
  input  wire logic          clk,
  input  wire logic [AW-1:0] i_addr,
  input  wire logic [3:0]    i_we,
  input  wire logic [31:0]   i_wdata,
  output logic      [31:0]   o_rdata
);

  // Contents are intentionally not reset so they can be preloaded.
  logic [7:0]    r_mem [DEPTH];
  logic [AW-1:0] w_lane_addr [4];

  generate
    for (genvar k = 0; k < 4; k++) begin : g_lane
      // Address arithmetic wraps naturally at DEPTH (power of two).
      assign w_lane_addr[k]       = i_addr + AW'(k);
      assign o_rdata[8*(3-k) +: 8] = r_mem[w_lane_addr[k]];
    end
  endgenerate

  always_ff @(posedge clk) begin
    for (int k = 0; k < 4; k++) begin
      if (i_we[k]) begin
        r_mem[w_lane_addr[k]] <= i_wdata[8*(3-k) +: 8];
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/ram_wait_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : ram_wait_ctrl
// Purpose : Byte-addressed big-endian memory with MOV/MOC handshake,
//           programmable wait states, byte/half/word access and fault
//           reporting. Request fields are latched at accept; writes commit
//           and read data is captured on the WAIT->ACK edge.
// Ports   : clk - clock, rising edge
//           rst - asynchronous active-high reset
//           bus - ram_wait_ctrl_if.slave (mov/rw/typ/addr/data_in in,
//                 data_out/moc/err/busy out)
// Revision: 1.0 - initial release
// ============================================================================
module ram_wait_ctrl
  import ram_wait_ctrl_pkg::*;
#(
  parameter int DEPTH       = 256,
  parameter int ADDR_W      = 32,
  parameter int WAIT_CYCLES = 2,
  parameter bit SIGN_EXT    = 1'b0
) (
  input wire logic       clk,
  input wire logic       rst,
  ram_wait_ctrl_if.slave bus
);

  localparam int         AW          = $clog2(DEPTH);
  localparam logic [3:0] c_wait_load = 4'(WAIT_CYCLES);

  state_e          r_state;
  state_e          w_state_nxt;
  logic [3:0]      r_cnt;
  logic            r_rw;
  logic [1:0]      r_type;
  logic [AW-1:0]   r_addr;
  logic [31:0]     r_wdata;
  logic            r_fault;
  logic [31:0]     r_rdata;
  logic            r_armed;

  logic            w_oob;
  logic            w_accept;
  logic            w_commit;
  logic [3:0]      w_we;
  logic [31:0]     w_wdata;
  logic [31:0]     w_rd;
  logic [31:0]     w_rd_value;

  // Any address bit above the storage index makes the access out of range.
  generate
    if (ADDR_W > AW) begin : g_oob
      assign w_oob = |bus.addr[ADDR_W-1:AW];
    end else begin : g_no_oob
      assign w_oob = 1'b0;
    end
  endgenerate

  // A held MOV only counts as a new request once it has been seen low at a
  // clock edge since the previous accept.
  assign w_accept = (r_state == S_IDLE) && bus.mov && r_armed;
  assign w_commit = (r_state == S_WAIT) && (r_cnt == 4'd0);

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_accept) w_state_nxt = S_WAIT;
      S_WAIT:  if (r_cnt == 4'd0) w_state_nxt = S_ACK;
      S_ACK:   if (!bus.mov) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // ------------------------------------------------------ lane steering
  always_comb begin
    w_we       = 4'b0000;
    w_wdata    = r_wdata;
    w_rd_value = 32'h0;
    case (acc_type_e'(r_type))
      TYPE_BYTE: begin
        w_we       = 4'b0001;
        w_wdata    = {r_wdata[7:0], 24'h0};
        w_rd_value = SIGN_EXT ? {{24{w_rd[31]}}, w_rd[31:24]}
                              : {24'h0, w_rd[31:24]};
      end
      TYPE_HALF: begin
        w_we       = 4'b0011;
        w_wdata    = {r_wdata[15:0], 16'h0};
        w_rd_value = SIGN_EXT ? {{16{w_rd[31]}}, w_rd[31:16]}
                              : {16'h0, w_rd[31:16]};
      end
      TYPE_WORD: begin
        w_we       = 4'b1111;
        w_wdata    = r_wdata;
        w_rd_value = w_rd;
      end
      default: begin
        w_we       = 4'b0000;
        w_rd_value = 32'h0;
      end
    endcase
    // Storage only changes on the commit edge of a clean write.
    if (!(w_commit && !r_fault && (r_rw == RW_WRITE))) begin
      w_we = 4'b0000;
    end
  end

  // --------------------------------------------------- request datapath
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt   <= 4'd0;
      r_rw    <= RW_READ;
      r_type  <= 2'b00;
      r_addr  <= '0;
      r_wdata <= 32'h0;
      r_fault <= 1'b0;
      r_rdata <= 32'h0;
      r_armed <= 1'b1;
    end else begin
      if (!bus.mov) begin
        r_armed <= 1'b1;
      end else if (w_accept) begin
        r_armed <= 1'b0;
      end

      if (w_accept) begin
        r_rw    <= bus.rw;
        r_type  <= bus.typ;
        r_addr  <= bus.addr[AW-1:0];
        r_wdata <= bus.data_in;
        r_fault <= access_fault(bus.typ, bus.addr[1:0], w_oob);
        r_cnt   <= c_wait_load;
      end else if ((r_state == S_WAIT) && (r_cnt != 4'd0)) begin
        r_cnt <= r_cnt - 4'd1;
      end

      if (w_commit) begin
        r_rdata <= ((r_rw == RW_READ) && !r_fault) ? w_rd_value : 32'h0;
      end else if ((r_state == S_ACK) && !bus.mov) begin
        r_rdata <= 32'h0;
      end
    end
  end

  ram_byte_array #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_array (
    .clk     (clk),
    .i_addr  (r_addr),
    .i_we    (w_we),
    .i_wdata (w_wdata),
    .o_rdata (w_rd)
  );

  assign bus.moc      = (r_state == S_ACK);
  assign bus.err      = (r_state == S_ACK) && r_fault;
  assign bus.busy     = (r_state != S_IDLE);
  assign bus.data_out = r_rdata;

endmodule
`default_nettype wire

// File: tb/tb_ram_wait_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : tb_ram_wait_ctrl
// Purpose : Directed self-checking bench. Instance A uses two wait states and
//           zero extension; instance B uses zero wait states and sign
//           extension.
// Revision: 1.0 - initial release
// ============================================================================
module tb_ram_wait_ctrl;
  import ram_wait_ctrl_pkg::*;

  logic clk;
  logic rst;
  int   n_total;
  int   n_bad;

  ram_wait_ctrl_if #(.ADDR_W(32)) bus_a ();
  ram_wait_ctrl_if #(.ADDR_W(32)) bus_b ();

  ram_wait_ctrl #(
    .DEPTH(256), .ADDR_W(32), .WAIT_CYCLES(2), .SIGN_EXT(1'b0)
  ) u_a (
    .clk (clk),
    .rst (rst),
    .bus (bus_a)
  );

  ram_wait_ctrl #(
    .DEPTH(256), .ADDR_W(32), .WAIT_CYCLES(0), .SIGN_EXT(1'b1)
  ) u_b (
    .clk (clk),
    .rst (rst),
    .bus (bus_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic req(input bit sel, input logic rw, input logic [1:0] typ,
                     input logic [31:0] addr, input logic [31:0] wd);
    @(negedge clk);
    bus_a.rw = rw; bus_a.typ = typ; bus_a.addr = addr; bus_a.data_in = wd;
    bus_b.rw = rw; bus_b.typ = typ; bus_b.addr = addr; bus_b.data_in = wd;
    if (sel) bus_b.mov = 1'b1;
    else     bus_a.mov = 1'b1;
  endtask

  // Counts rising edges from the accept edge up to and including the edge
  // after which MOC is seen.
  task automatic wait_moc(input bit sel, input string tag, output int lat);
    logic seen;
    seen = 1'b0;
    lat  = 0;
    while (!seen && lat < 40) begin
      @(posedge clk); #1;
      lat++;
      seen = sel ? bus_b.moc : bus_a.moc;
    end
    if (!seen) chk({tag, "/timeout"}, {31'h0, seen}, 32'h1);
  endtask

  task automatic release_req(input bit sel);
    @(negedge clk);
    if (sel) bus_b.mov = 1'b0;
    else     bus_a.mov = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic xfer(input string tag, input bit sel, input logic rw,
                      input logic [1:0] typ, input logic [31:0] addr,
                      input logic [31:0] wd, input int exp_lat,
                      input logic exp_err, input logic [31:0] exp_data);
    int lat;
    req(sel, rw, typ, addr, wd);
    wait_moc(sel, tag, lat);
    chk({tag, "/lat"},  lat, exp_lat);
    chk({tag, "/err"},  {31'h0, sel ? bus_b.err : bus_a.err}, {31'h0, exp_err});
    chk({tag, "/data"}, sel ? bus_b.data_out : bus_a.data_out, exp_data);
    release_req(sel);
    chk({tag, "/moc_rel"},  {31'h0, sel ? bus_b.moc : bus_a.moc}, 32'h0);
    chk({tag, "/data_rel"}, sel ? bus_b.data_out : bus_a.data_out, 32'h0);
  endtask

  initial begin
    int lat;
    n_total = 0;
    n_bad   = 0;
    rst = 1'b1;
    bus_a.mov = 1'b0; bus_a.rw = RW_READ; bus_a.typ = TYPE_BYTE; bus_a.addr = 32'h0; bus_a.data_in = 32'h0;
    bus_b.mov = 1'b0; bus_b.rw = RW_READ; bus_b.typ = TYPE_BYTE; bus_b.addr = 32'h0; bus_b.data_in = 32'h0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;

    // Reset state
    chk("rst/moc",  {31'h0, bus_a.moc},  32'h0);
    chk("rst/err",  {31'h0, bus_a.err},  32'h0);
    chk("rst/busy", {31'h0, bus_a.busy}, 32'h0);
    chk("rst/data", bus_a.data_out,      32'h0);

    // Preload
    u_a.u_array.r_mem[0]  = 8'hDE; u_a.u_array.r_mem[1]  = 8'hAD;
    u_a.u_array.r_mem[2]  = 8'hBE; u_a.u_array.r_mem[3]  = 8'hEF;
    u_a.u_array.r_mem[4]  = 8'h44; u_a.u_array.r_mem[5]  = 8'h55;
    u_a.u_array.r_mem[6]  = 8'h66; u_a.u_array.r_mem[7]  = 8'h77;
    u_a.u_array.r_mem[8]  = 8'h88; u_a.u_array.r_mem[9]  = 8'h99;
    u_a.u_array.r_mem[10] = 8'hAA; u_a.u_array.r_mem[11] = 8'hBB;
    u_b.u_array.r_mem[0]  = 8'h01; u_b.u_array.r_mem[1]  = 8'h02;
    u_b.u_array.r_mem[2]  = 8'h03; u_b.u_array.r_mem[3]  = 8'h04;

    // Word read, two wait states
    xfer("rd_w0", 1'b0, RW_READ, TYPE_WORD, 32'd0, 32'h0, 4, 1'b0, 32'hDEADBEEF);

    // Halfword write then narrow reads (zero extension)
    xfer("wr_h6", 1'b0, RW_WRITE, TYPE_HALF, 32'd6, 32'h00001234, 4, 1'b0, 32'h0);
    chk("mem6", {24'h0, u_a.u_array.r_mem[6]}, 32'h12);
    chk("mem7", {24'h0, u_a.u_array.r_mem[7]}, 32'h34);
    xfer("rd_b7", 1'b0, RW_READ, TYPE_BYTE, 32'd7, 32'h0, 4, 1'b0, 32'h00000034);
    xfer("rd_h6", 1'b0, RW_READ, TYPE_HALF, 32'd6, 32'h0, 4, 1'b0, 32'h00001234);
    xfer("rd_b0", 1'b0, RW_READ, TYPE_BYTE, 32'd0, 32'h0, 4, 1'b0, 32'h000000DE);

    // Faulting accesses: no storage change, data 0
    xfer("err_w2", 1'b0, RW_WRITE, TYPE_WORD, 32'd2, 32'hFFFFFFFF, 4, 1'b1, 32'h0);
    chk("err_w2/mem2", {24'h0, u_a.u_array.r_mem[2]}, 32'hBE);
    chk("err_w2/mem5", {24'h0, u_a.u_array.r_mem[5]}, 32'h55);
    xfer("err_rw2", 1'b0, RW_READ, TYPE_WORD, 32'd2, 32'h0, 4, 1'b1, 32'h0);
    xfer("err_h5", 1'b0, RW_WRITE, TYPE_HALF, 32'd5, 32'h0000ABCD, 4, 1'b1, 32'h0);
    chk("err_h5/mem5", {24'h0, u_a.u_array.r_mem[5]}, 32'h55);
    chk("err_h5/mem6", {24'h0, u_a.u_array.r_mem[6]}, 32'h12);
    xfer("err_rsvd", 1'b0, RW_READ, TYPE_RSVD, 32'd0, 32'h0, 4, 1'b1, 32'h0);
    xfer("err_oob", 1'b0, RW_READ, TYPE_WORD, 32'd256, 32'h0, 4, 1'b1, 32'h0);
    xfer("err_oobw", 1'b0, RW_WRITE, TYPE_BYTE, 32'd264, 32'h0000005A, 4, 1'b1, 32'h0);
    chk("err_oobw/mem8", {24'h0, u_a.u_array.r_mem[8]}, 32'h88);

    // MOV held after MOC: no second access; low for one edge re-arms
    req(1'b0, RW_READ, TYPE_WORD, 32'd0, 32'h0);
    wait_moc(1'b0, "hold", lat);
    chk("hold/lat", lat, 4);
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      chk("hold/moc",  {31'h0, bus_a.moc}, 32'h1);
      chk("hold/data", bus_a.data_out, 32'hDEADBEEF);
    end
    release_req(1'b0);
    chk("hold/moc_rel",  {31'h0, bus_a.moc},  32'h0);
    chk("hold/busy_rel", {31'h0, bus_a.busy}, 32'h0);
    req(1'b0, RW_READ, TYPE_HALF, 32'd2, 32'h0);
    wait_moc(1'b0, "rearm", lat);
    chk("rearm/lat",  lat, 4);
    chk("rearm/data", bus_a.data_out, 32'h0000BEEF);
    release_req(1'b0);

    // Reset while a write is waiting: discarded
    req(1'b0, RW_WRITE, TYPE_WORD, 32'd8, 32'hCAFEF00D);
    @(posedge clk); #1;
    chk("clr/busy_pre", {31'h0, bus_a.busy}, 32'h1);
    @(posedge clk); #2;
    rst = 1'b1;
    bus_a.mov = 1'b0;
    #2;
    rst = 1'b0;
    #1;
    chk("clr/moc",  {31'h0, bus_a.moc},  32'h0);
    chk("clr/err",  {31'h0, bus_a.err},  32'h0);
    chk("clr/busy", {31'h0, bus_a.busy}, 32'h0);
    chk("clr/data", bus_a.data_out,      32'h0);
    chk("clr/mem8",  {24'h0, u_a.u_array.r_mem[8]},  32'h88);
    chk("clr/mem9",  {24'h0, u_a.u_array.r_mem[9]},  32'h99);
    chk("clr/mem10", {24'h0, u_a.u_array.r_mem[10]}, 32'hAA);
    chk("clr/mem11", {24'h0, u_a.u_array.r_mem[11]}, 32'hBB);
    xfer("clr_rd", 1'b0, RW_READ, TYPE_WORD, 32'd8, 32'h0, 4, 1'b0, 32'h8899AABB);

    // Zero wait states with sign extension
    xfer("b_rd_w0", 1'b1, RW_READ,  TYPE_WORD, 32'd0, 32'h0, 2, 1'b0, 32'h01020304);
    xfer("b_wr_h6", 1'b1, RW_WRITE, TYPE_HALF, 32'd6, 32'h00008001, 2, 1'b0, 32'h0);
    xfer("b_rd_h6", 1'b1, RW_READ,  TYPE_HALF, 32'd6, 32'h0, 2, 1'b0, 32'hFFFF8001);
    xfer("b_rd_b6", 1'b1, RW_READ,  TYPE_BYTE, 32'd6, 32'h0, 2, 1'b0, 32'hFFFFFF80);
    xfer("b_rd_b7", 1'b1, RW_READ,  TYPE_BYTE, 32'd7, 32'h0, 2, 1'b0, 32'h00000001);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
